// File: rtl/rbot_pkg.sv
// rbot_pkg: shared face encodings and move-sequencer state type.
package rbot_pkg;
  localparam int NUM_FACES = 6;
  localparam logic [2:0] FACE_U = 3'd0;
  localparam logic [2:0] FACE_R = 3'd1;
  localparam logic [2:0] FACE_F = 3'd2;
  localparam logic [2:0] FACE_D = 3'd3;
  localparam logic [2:0] FACE_L = 3'd4;
  localparam logic [2:0] FACE_B = 3'd5;
  typedef enum logic [2:0] {IDLE, SETUP, STEP, SETTLE, DONE} seq_state_t;
endpackage

// File: rtl/tick_sync.sv
// tick_sync: synchronizes the slow_clock level and flags each rising edge as a one-cycle tick.
module tick_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic tick
);
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;
  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end
  // Reset high so a divider that idles high does not look like a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end
  assign tick = s2_q & ~s3_q;
endmodule

// File: rtl/stepper_move_sequencer.sv
// stepper_move_sequencer: turns one cube-move command into a tick-paced burst of step pulses on one face motor.
module stepper_move_sequencer
  import rbot_pkg::*;
#(
  parameter int NUM_MOTORS        = NUM_FACES,
  parameter int STEPS_PER_QUARTER = 50,
  parameter int PULSE_CYCLES      = 250,
  parameter int SETTLE_TICKS      = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  slow_clock,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_face,
  input  logic                  cmd_dir,
  input  logic                  cmd_double,
  output logic [NUM_MOTORS-1:0] step,
  output logic [NUM_MOTORS-1:0] dir,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int RW = $clog2(2*STEPS_PER_QUARTER+1);
  localparam int PW = $clog2(PULSE_CYCLES+1);
  localparam int SW = $clog2(SETTLE_TICKS+1);
  seq_state_t state_q, state_d;
  logic [2:0] face_q, face_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [NUM_MOTORS-1:0] step_q, step_d, dir_q, dir_d, face_mask;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, cmd_ready_q, cmd_ready_d;
  logic tick;
  tick_sync u_tick_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(slow_clock),
    .tick    (tick)
  );
  assign face_mask = NUM_MOTORS'(1) << cmd_face;
  always_comb begin
    state_d = state_q;
    face_d  = face_q;
    rem_d   = rem_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (32'(cmd_face) < NUM_MOTORS) begin
            state_d = SETUP;
            face_d  = cmd_face;
            rem_d   = cmd_double ? RW'(2*STEPS_PER_QUARTER) : RW'(STEPS_PER_QUARTER);
            dir_d   = cmd_dir ? (dir_q | face_mask) : (dir_q & ~face_mask);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // The first tick only arms stepping, giving dir a full tick period of setup.
      SETUP: state_d = tick ? STEP : SETUP;
      STEP: begin
        if (pcnt_q != '0) begin
          pcnt_d = pcnt_q - PW'(1);
          if (pcnt_q == PW'(1)) begin
            step_d = '0;
            if (rem_q == '0) begin
              state_d = SETTLE;
              scnt_d  = SW'(SETTLE_TICKS);
            end
          end
        end else if (tick && rem_q != '0) begin
          step_d = NUM_MOTORS'(1) << face_q;
          pcnt_d = PW'(PULSE_CYCLES);
          rem_d  = rem_q - RW'(1);
        end
      end
      SETTLE: begin
        if (tick && scnt_q != '0) begin
          scnt_d = scnt_q - SW'(1);
          if (scnt_q == SW'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = state_d != IDLE;
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      face_q      <= '0;
      rem_q       <= '0;
      pcnt_q      <= '0;
      scnt_q      <= '0;
      step_q      <= '0;
      dir_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      face_q      <= face_d;
      rem_q       <= rem_d;
      pcnt_q      <= pcnt_d;
      scnt_q      <= scnt_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end
  assign step      = step_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = cmd_ready_q;
endmodule
